matriz_led_regs: RTL and testbench

- Bus-slave register block that sits directly upstream of the 4x8 LED matrix multiplexing controller.
- Holds the four 8-bit row patterns that drive the controller's leds1..leds4 inputs.
- Adds a hardware horizontal-scroll engine (per-row byte rotation at a programmable rate), a blank control and a wrap interrupt.
- The CPU reaches it through the native valid/ready memory bus; an address decoder supplies the select.

---
 rtl/matriz_led_regs_pkg.sv | 65 ++++++
 rtl/divisor_tick.sv | 49 ++++
 rtl/matriz_led_regs.sv | 171 +++++++++++++++++
 tb/tb_matriz_led_regs.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/matriz_led_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matriz_led_regs_pkg
// Description : Shared register offsets, CTRL bit positions, reset constants
//               and small helpers for the LED matrix register block.
// Revision    : 1.0 - initial release
// ============================================================================
package matriz_led_regs_pkg;

    // Register byte offsets inside the block.
    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;
    localparam logic [3:0] ADDR_DIV    = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    // CTRL register bit positions.
    localparam int CTRL_SCROLL_EN = 0;
    localparam int CTRL_DIR       = 1;
    localparam int CTRL_BLANK     = 2;
    localparam int CTRL_IRQ_EN    = 3;

    // Default scroll prescaler: 12 MHz / 1.5M = 8 scroll steps per second.
    localparam logic [23:0] DIV_RESET_DEFAULT = 24'd1_500_000;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_DIV    = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    // Word address bits [3:2] select the register; the byte lane bits are ignored.
    function automatic reg_sel_e decode_reg(input logic [1:0] word_addr);
        reg_sel_e sel_v;
        case ({word_addr, 2'b00})
            ADDR_DATA:   sel_v = REG_DATA;
            ADDR_CTRL:   sel_v = REG_CTRL;
            ADDR_DIV:    sel_v = REG_DIV;
            ADDR_STATUS: sel_v = REG_STATUS;
            default:     sel_v = REG_DATA;
        endcase
        return sel_v;
    endfunction

    // Replace the byte lanes of old_w whose strobe is set with those of new_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // One-position byte rotation: dir=0 rotates left, dir=1 rotates right.
    function automatic logic [7:0] rot_byte(input logic [7:0] b, input logic dir);
        return dir ? {b[0], b[7:1]} : {b[6:0], b[7]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_tick.sv
`default_nettype none
// ============================================================================
// Module      : divisor_tick
// Description : Programmable prescaler. Counts 0..div-1 while enabled and
//               pulses tick for one cycle on the wrap. div=0 acts as div=1.
//               Disabling or clearing returns the count to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_tick #(
    parameter int DIV_W = 24
) (
    input  logic             clk12Mhz,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] last_cnt;

    // Next count and wrap pulse; div=0 collapses to a terminal count of 0.
    always_comb begin
        last_cnt = (div == '0) ? '0 : (div - DIV_W'(1));
        cnt_d    = cnt_q;
        tick     = 1'b0;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q >= last_cnt) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk12Mhz) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matriz_led_regs.sv
`default_nettype none
// ============================================================================
// Module      : matriz_led_regs
// Description : Bus-slave register block feeding the 4x8 LED matrix
//               controller: four row patterns, horizontal scroll engine,
//               blanking and a wrap interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module matriz_led_regs
    import matriz_led_regs_pkg::*;
#(
    parameter int               DIV_W     = 24,
    parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_RESET_DEFAULT)
) (
    input  logic        clk12Mhz,
    input  logic        rst,
    input  logic        sel,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [7:0]  leds1,
    output logic [7:0]  leds2,
    output logic [7:0]  leds3,
    output logic [7:0]  leds4,
    output logic        irq
);

    // Architectural state.
    logic [31:0]      data_q,   data_d;
    logic [3:0]       ctrl_q,   ctrl_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [2:0]       step_q,   step_d;
    logic             wrap_q,   wrap_d;

    // Bus and output registers.
    logic             mem_ready_q, mem_ready_d;
    logic [31:0]      mem_rdata_q, mem_rdata_d;
    logic [31:0]      leds_q,      leds_d;
    logic             irq_q,       irq_d;

    // Decoded bus request.
    logic     req;
    logic     is_wr;
    logic     is_rd;
    reg_sel_e reg_sel;
    logic     wr_data;
    logic     wr_ctrl;
    logic     wr_div;
    logic     wr_status;
    logic     tick;
    logic     wrap_set;
    logic     unused_addr_bits;

    // Byte-lane address bits carry no meaning for word registers.
    assign unused_addr_bits = ^mem_addr[1:0];

    // Request qualification: mem_ready in flight blocks a second request,
    // so back-to-back accesses are acknowledged at most every other cycle.
    always_comb begin
        req       = sel & mem_valid & ~mem_ready_q;
        is_wr     = req & (|mem_wstrb);
        is_rd     = req & ~(|mem_wstrb);
        reg_sel   = decode_reg(mem_addr[3:2]);
        wr_data   = is_wr && (reg_sel == REG_DATA);
        wr_ctrl   = is_wr && (reg_sel == REG_CTRL);
        wr_div    = is_wr && (reg_sel == REG_DIV);
        wr_status = is_wr && (reg_sel == REG_STATUS);
    end

    divisor_tick #(
        .DIV_W (DIV_W)
    ) u_divisor_tick (
        .clk12Mhz (clk12Mhz),
        .rst      (rst),
        .en       (ctrl_q[CTRL_SCROLL_EN]),
        .clr      (wr_div),
        .div      (div_q),
        .tick     (tick)
    );

    // Register writes and scroll engine. A DATA write restarts the scroll
    // phase and beats a same-cycle rotation; a wrap set beats a W1C clear.
    always_comb begin
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        step_d   = step_q;
        wrap_d   = wrap_q;
        wrap_set = 1'b0;

        if (wr_data) begin
            data_d = merge_bytes(data_q, mem_wdata, mem_wstrb);
            step_d = 3'd0;
        end else if (tick && ctrl_q[CTRL_SCROLL_EN]) begin
            for (int i = 0; i < 4; i++) begin
                data_d[8*i +: 8] = rot_byte(data_q[8*i +: 8], ctrl_q[CTRL_DIR]);
            end
            step_d   = step_q + 3'd1;
            wrap_set = (step_q == 3'd7);
        end

        if (wr_ctrl && mem_wstrb[0]) begin
            ctrl_d = mem_wdata[3:0];
        end

        if (wr_div) begin
            div_d = DIV_W'(merge_bytes(32'(div_q), mem_wdata, mem_wstrb & 4'b0111));
        end

        if (wr_status && mem_wstrb[0] && mem_wdata[0]) begin
            wrap_d = 1'b0;
        end
        if (wrap_set) begin
            wrap_d = 1'b1;
        end
    end

    // Acknowledge, read mux and registered outputs toward the matrix.
    always_comb begin
        mem_ready_d = req;
        mem_rdata_d = 32'd0;
        if (is_rd) begin
            case (reg_sel)
                REG_DATA:   mem_rdata_d = data_q;
                REG_CTRL:   mem_rdata_d = {28'd0, ctrl_q};
                REG_DIV:    mem_rdata_d = 32'(div_q);
                REG_STATUS: mem_rdata_d = {28'd0, step_q, wrap_q};
            endcase
        end
        leds_d = ctrl_q[CTRL_BLANK] ? 32'd0 : data_q;
        irq_d  = wrap_q & ctrl_q[CTRL_IRQ_EN];
    end

    // State registers; reset also discards any write pending on this edge.
    always_ff @(posedge clk12Mhz) begin
        if (rst) begin
            data_q      <= 32'd0;
            ctrl_q      <= 4'd0;
            div_q       <= DIV_RESET;
            step_q      <= 3'd0;
            wrap_q      <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'd0;
            leds_q      <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            div_q       <= div_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            leds_q      <= leds_d;
            irq_q       <= irq_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign leds1     = leds_q[7:0];
    assign leds2     = leds_q[15:8];
    assign leds3     = leds_q[23:16];
    assign leds4     = leds_q[31:24];
    assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_matriz_led_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_matriz_led_regs
// Description : Directed self-checking bench for matriz_led_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matriz_led_regs;

    logic        clk12Mhz;
    logic        rst;
    logic        sel;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [7:0]  leds1;
    logic [7:0]  leds2;
    logic [7:0]  leds3;
    logic [7:0]  leds4;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    matriz_led_regs dut (
        .clk12Mhz  (clk12Mhz),
        .rst       (rst),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .leds1     (leds1),
        .leds2     (leds2),
        .leds3     (leds3),
        .leds4     (leds4),
        .irq       (irq)
    );

    initial clk12Mhz = 1'b0;
    always #5 clk12Mhz = ~clk12Mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        sel       = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 4'h0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        repeat (3) @(negedge clk12Mhz);
        rst = 1'b0;
    endtask

    // Called on a falling edge; returns two falling edges later.
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        sel       = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = strb;
        @(negedge clk12Mhz);
        check("wr_ack_high", 32'(mem_ready), 32'd1);
        sel       = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        @(negedge clk12Mhz);
        check("wr_ack_low", 32'(mem_ready), 32'd0);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        sel       = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = 4'd0;
        @(negedge clk12Mhz);
        check("rd_ack_high", 32'(mem_ready), 32'd1);
        data      = mem_rdata;
        sel       = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk12Mhz);
        check("rd_ack_low", 32'(mem_ready), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  pat;

        // Reset state.
        reset_dut();
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_leds", {leds4, leds3, leds2, leds1}, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // Full-word DATA write and readback.
        bus_write(4'h0, 32'h8001FF3C, 4'b1111);
        check("t1_leds1", 32'(leds1), 32'h3C);
        check("t1_leds2", 32'(leds2), 32'hFF);
        check("t1_leds3", 32'(leds3), 32'h01);
        check("t1_leds4", 32'(leds4), 32'h80);
        bus_read(4'h0, rd);
        check("t1_read_data", rd, 32'h8001FF3C);
        check("t1_rdata_idle", mem_rdata, 32'd0);

        // Single-byte strobe, CTRL and DIV reset values.
        bus_write(4'h0, 32'h0000AA00, 4'b0010);
        check("t2_leds1", 32'(leds1), 32'h3C);
        check("t2_leds2", 32'(leds2), 32'hAA);
        check("t2_leds3", 32'(leds3), 32'h01);
        check("t2_leds4", 32'(leds4), 32'h80);
        bus_read(4'h4, rd);
        check("t2_ctrl", rd, 32'h0);
        bus_read(4'h8, rd);
        check("t2_div", rd, 32'h0016E360);

        // Left scroll with DIV=3: leds1 doubles every third cycle.
        bus_write(4'h8, 32'd3, 4'b1111);
        bus_write(4'h0, 32'h00000001, 4'b1111);
        bus_write(4'h4, 32'h1, 4'b0001);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk12Mhz);
            pat = 8'h01;
            for (int k = 0; k < (i / 3) % 8; k++) pat = {pat[6:0], pat[7]};
            check("t3_leds1", 32'(leds1), 32'(pat));
        end
        bus_read(4'hC, rd);
        check("t3_status", rd, 32'h1);
        check("t3_irq", 32'(irq), 32'd0);

        // Right scroll with DIV=1 and irq enabled.
        reset_dut();
        bus_write(4'h8, 32'd1, 4'b1111);
        bus_write(4'h0, 32'h00000080, 4'b0001);
        bus_write(4'h4, 32'hB, 4'b0001);
        check("t4_leds1_start", 32'(leds1), 32'h80);
        pat = 8'h80;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk12Mhz);
            pat = {pat[0], pat[7:1]};
            check("t4_leds1", 32'(leds1), 32'(pat));
            check("t4_irq", 32'(irq), (i == 8) ? 32'd1 : 32'd0);
        end
        bus_write(4'hC, 32'h1, 4'b0001);
        check("t4_irq_cleared", 32'(irq), 32'd0);
        repeat (4) @(negedge clk12Mhz);
        check("t4_irq_low_before_wrap", 32'(irq), 32'd0);
        bus_write(4'hC, 32'h1, 4'b0001);
        check("t4_w1c_vs_set", 32'(irq), 32'd1);

        // Blank while scrolling; step keeps advancing.
        bus_write(4'h4, 32'h5, 4'b0001);
        check("t5_blank_leds", {leds4, leds3, leds2, leds1}, 32'd0);
        bus_read(4'hC, rd);
        check("t5_status_a", rd, 32'h7);
        bus_read(4'hC, rd);
        check("t5_status_b", rd, 32'hB);
        check("t5_blank_leds_again", {leds4, leds3, leds2, leds1}, 32'd0);

        // DATA write on a tick cycle: unrotated value, step restarts.
        bus_write(4'h4, 32'h1, 4'b0001);
        bus_write(4'h0, 32'h12345678, 4'b1111);
        check("t5_wr_leds1", 32'(leds1), 32'h78);
        check("t5_wr_leds2", 32'(leds2), 32'h56);
        check("t5_wr_leds3", 32'(leds3), 32'h34);
        check("t5_wr_leds4", 32'(leds4), 32'h12);
        bus_read(4'hC, rd);
        check("t5_step_restart", rd, 32'h3);

        // Reset on the edge that would acknowledge a DATA write.
        rst       = 1'b1;
        sel       = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = 4'h0;
        mem_wdata = 32'hDEADBEEF;
        mem_wstrb = 4'b1111;
        @(negedge clk12Mhz);
        check("t6_no_ack", 32'(mem_ready), 32'd0);
        check("t6_rdata", mem_rdata, 32'd0);
        check("t6_leds", {leds4, leds3, leds2, leds1}, 32'd0);
        check("t6_irq", 32'(irq), 32'd0);
        rst       = 1'b0;
        sel       = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        bus_read(4'h0, rd);
        check("t6_data", rd, 32'd0);
        bus_read(4'h4, rd);
        check("t6_ctrl", rd, 32'd0);
        bus_read(4'h8, rd);
        check("t6_div", rd, 32'h0016E360);
        bus_read(4'hC, rd);
        check("t6_status", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
